// File: rtl/viterbi_ber_monitor.sv
// BER monitor: aligns captured source bits with decoded bits through a FIFO and
// accumulates bit/error/burst statistics plus a HUNT/LOCKED lock detector.
module viterbi_ber_monitor #(
    parameter int DEPTH    = 64,
    parameter int LOCK_RUN = 32,
    parameter int LOSS_RUN = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             src_valid_i,
    input  logic             src_bit_i,
    input  logic             dec_valid_i,
    input  logic             dec_bit_i,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [15:0]      max_burst_o,
    output logic             locked_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [15:0]      RUN_MAX = 16'hFFFF;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic        r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [15:0] r_run;
    logic [15:0] r_match;
    state_t      r_state;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_head;
    logic        w_mis;
    logic [15:0] w_runNext;
    logic [15:0] w_matchNext;
    logic [CNT_W-1:0] w_bitNext;
    logic [CNT_W-1:0] w_errNext;
    state_t      w_stateNext;

    // Flags come from the start-of-cycle pointers; a pop frees room for a push while full.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = dec_valid_i && !w_empty;
    assign w_push  = src_valid_i && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_mis   = w_head ^ dec_bit_i;

    assign w_runNext   = w_mis ? ((r_run == RUN_MAX) ? r_run : r_run + 16'd1) : 16'd0;
    assign w_matchNext = w_mis ? 16'd0 : ((r_match == RUN_MAX) ? r_match : r_match + 16'd1);
    assign w_bitNext   = (bit_count_o == CNT_MAX) ? bit_count_o : bit_count_o + CNT_ONE;
    assign w_errNext   = (w_mis && err_count_o != CNT_MAX) ? err_count_o + CNT_ONE : err_count_o;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            HUNT:    if (w_matchNext >= 16'(LOCK_RUN)) w_stateNext = LOCKED;
            LOCKED:  if (w_runNext >= 16'(LOSS_RUN))   w_stateNext = HUNT;
            default: w_stateNext = HUNT;
        endcase
    end

    assign locked_o = (r_state == LOCKED);

    always_ff @(posedge clk) begin
        if (w_push && !clear_i) begin
            r_mem[r_wptr[AW-1:0]] <= src_bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_run       <= '0;
            r_match     <= '0;
            r_state     <= HUNT;
            err_pulse_o <= 1'b0;
            bit_count_o <= '0;
            err_count_o <= '0;
            max_burst_o <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_run       <= '0;
            r_match     <= '0;
            r_state     <= HUNT;
            err_pulse_o <= 1'b0;
            bit_count_o <= '0;
            err_count_o <= '0;
            max_burst_o <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            err_pulse_o <= w_pop && w_mis;
            if (w_pop) begin
                r_rptr      <= r_rptr + PTR_ONE;
                bit_count_o <= w_bitNext;
                err_count_o <= w_errNext;
                r_run       <= w_runNext;
                r_state     <= w_stateNext;
                if (w_runNext > max_burst_o) begin
                    max_burst_o <= w_runNext;
                end
                // Leaving LOCKED restarts the hunt from an empty match run.
                if (r_state == LOCKED && w_stateNext == HUNT) begin
                    r_match <= '0;
                end else begin
                    r_match <= w_matchNext;
                end
            end
            if (src_valid_i && w_full && !dec_valid_i) begin
                overflow_o <= 1'b1;
            end
            if (dec_valid_i && w_empty) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Scoreboard bench for viterbi_ber_monitor: a queue-based reference model pushes
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_viterbi_ber_monitor;

    localparam int DEPTH    = 64;
    localparam int LOCK_RUN = 32;
    localparam int LOSS_RUN = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clearIn;
    logic        srcValid;
    logic        srcBit;
    logic        decValid;
    logic        decBit;
    logic        errPulse;
    logic [31:0] bitCount;
    logic [31:0] errCount;
    logic [15:0] maxBurst;
    logic        locked;
    logic        overflow;
    logic        underflow;

    logic        s4SrcValid;
    logic        s4SrcBit;
    logic        s4DecValid;
    logic        s4DecBit;
    logic        s4Clear;
    logic        s4Pulse;
    logic [3:0]  s4Bit;
    logic [3:0]  s4Err;
    logic [15:0] s4Max;
    logic        s4Locked;
    logic        s4Ovf;
    logic        s4Udf;

    viterbi_ber_monitor #(.DEPTH(DEPTH), .LOCK_RUN(LOCK_RUN), .LOSS_RUN(LOSS_RUN), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .clear_i(clearIn),
        .src_valid_i(srcValid), .src_bit_i(srcBit),
        .dec_valid_i(decValid), .dec_bit_i(decBit),
        .err_pulse_o(errPulse), .bit_count_o(bitCount), .err_count_o(errCount),
        .max_burst_o(maxBurst), .locked_o(locked),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    viterbi_ber_monitor #(.DEPTH(DEPTH), .LOCK_RUN(LOCK_RUN), .LOSS_RUN(LOSS_RUN), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear_i(s4Clear),
        .src_valid_i(s4SrcValid), .src_bit_i(s4SrcBit),
        .dec_valid_i(s4DecValid), .dec_bit_i(s4DecBit),
        .err_pulse_o(s4Pulse), .bit_count_o(s4Bit), .err_count_o(s4Err),
        .max_burst_o(s4Max), .locked_o(s4Locked),
        .overflow_o(s4Ovf), .underflow_o(s4Udf)
    );

    typedef struct {
        logic        errPulse;
        logic [31:0] bitCount;
        logic [31:0] errCount;
        logic [15:0] maxBurst;
        logic        locked;
        logic        overflow;
        logic        underflow;
    } exp_t;

    exp_t expQ[$];
    exp_t expItem;
    int   checks = 0;
    int   errors = 0;
    int   pulseCnt = 0;

    bit   mQ[$];
    int   mBit, mErr, mRun, mMax, mMatch;
    logic mLocked, mOvf, mUdf, mPulse;

    logic srcPat  [256];
    logic lockHist[256];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mBit = 0; mErr = 0; mRun = 0; mMax = 0; mMatch = 0;
        mLocked = 1'b0; mOvf = 1'b0; mUdf = 1'b0; mPulse = 1'b0;
    endtask

    task automatic modelStep(input logic sv, input logic sb, input logic dv, input logic db, input logic clr);
        bit isFull, isEmpty, popped, mis;
        if (clr) begin
            modelReset();
            return;
        end
        isFull  = (mQ.size() == DEPTH);
        isEmpty = (mQ.size() == 0);
        popped  = dv && !isEmpty;
        mPulse  = 1'b0;
        if (popped) begin
            mis    = mQ.pop_front() ^ db;
            mPulse = mis;
            mBit++;
            if (mis) begin
                mErr++;
                mRun++;
                mMatch = 0;
            end else begin
                mRun = 0;
                mMatch++;
            end
            if (mRun > mMax) mMax = mRun;
            if (!mLocked && mMatch >= LOCK_RUN) begin
                mLocked = 1'b1;
            end else if (mLocked && mRun >= LOSS_RUN) begin
                mLocked = 1'b0;
                mMatch  = 0;
            end
        end
        if (dv && isEmpty) mUdf = 1'b1;
        if (sv) begin
            if (isFull && !popped) mOvf = 1'b1;
            else mQ.push_back(sb);
        end
    endtask

    // Drive one cycle, let the DUT take the edge, then queue what the model predicts.
    task automatic applyStimulus(input logic sv, input logic sb, input logic dv, input logic db, input logic clr);
        srcValid = sv; srcBit = sb; decValid = dv; decBit = db; clearIn = clr;
        @(posedge clk);
        #1;
        pulseCnt += int'(errPulse);
        modelStep(sv, sb, dv, db, clr);
        expQ.push_back('{errPulse: mPulse, bitCount: 32'(mBit), errCount: 32'(mErr),
                         maxBurst: 16'(mMax), locked: mLocked, overflow: mOvf, underflow: mUdf});
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            expItem = expQ.pop_front();
            checkOutput("err_pulse_o", 32'(errPulse), 32'(expItem.errPulse));
            checkOutput("bit_count_o", bitCount, expItem.bitCount);
            checkOutput("err_count_o", errCount, expItem.errCount);
            checkOutput("max_burst_o", 32'(maxBurst), 32'(expItem.maxBurst));
            checkOutput("locked_o", 32'(locked), 32'(expItem.locked));
            checkOutput("overflow_o", 32'(overflow), 32'(expItem.overflow));
            checkOutput("underflow_o", 32'(underflow), 32'(expItem.underflow));
        end
    end

    // Source stream with the decoded copy trailing by 10 cycles; compares invLo..invHi are inverted.
    task automatic runStream(input int n, input int invLo, input int invHi);
        logic db;
        for (int i = 0; i < n; i++) srcPat[i] = 1'($urandom);
        for (int c = 0; c < n + 10; c++) begin
            db = 1'b0;
            if (c >= 10) db = srcPat[c-10] ^ ((c - 10 >= invLo) && (c - 10 <= invHi));
            applyStimulus(c < n, (c < n) ? srcPat[c] : 1'b0, c >= 10, db, 1'b0);
            if (c >= 10) lockHist[c-10] = locked;
        end
    endtask

    task automatic doClear();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clear bit_count_o", bitCount, 32'd0);
        checkOutput("clear err_count_o", errCount, 32'd0);
        checkOutput("clear max_burst_o", 32'(maxBurst), 32'd0);
        checkOutput("clear locked_o", 32'(locked), 32'd0);
        checkOutput("clear flags", {30'd0, overflow, underflow}, 32'd0);
        pulseCnt = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        clearIn = 1'b0; srcValid = 1'b0; srcBit = 1'b0; decValid = 1'b0; decBit = 1'b0;
        s4Clear = 1'b0; s4SrcValid = 1'b0; s4SrcBit = 1'b0; s4DecValid = 1'b0; s4DecBit = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset bit_count_o", bitCount, 32'd0);
        checkOutput("reset locked_o", 32'(locked), 32'd0);
        rst = 1'b1;

        $display("[TB] error-free loop");
        runStream(200, 1000, 1000);
        checkOutput("loop bit_count_o", bitCount, 32'd200);
        checkOutput("loop err_count_o", errCount, 32'd0);
        checkOutput("loop max_burst_o", 32'(maxBurst), 32'd0);
        checkOutput("loop locked_o", 32'(locked), 32'd1);
        checkOutput("loop flags", {30'd0, overflow, underflow}, 32'd0);
        checkOutput("lock after 31 compares", 32'(lockHist[30]), 32'd0);
        checkOutput("lock after 32 compares", 32'(lockHist[31]), 32'd1);

        $display("[TB] injected burst");
        doClear();
        runStream(60, 40, 42);
        checkOutput("burst err_count_o", errCount, 32'd3);
        checkOutput("burst max_burst_o", 32'(maxBurst), 32'd3);
        checkOutput("burst pulse count", 32'(pulseCnt), 32'd3);
        checkOutput("burst locked_o", 32'(locked), 32'd1);
        checkOutput("burst bit_count_o", bitCount, 32'd60);

        $display("[TB] loss of lock");
        doClear();
        runStream(90, 40, 47);
        checkOutput("loss lock after 7 errs", 32'(lockHist[46]), 32'd1);
        checkOutput("loss lock after 8 errs", 32'(lockHist[47]), 32'd0);
        checkOutput("relock after 31 clean", 32'(lockHist[78]), 32'd0);
        checkOutput("relock after 32 clean", 32'(lockHist[79]), 32'd1);
        checkOutput("loss max_burst_o", 32'(maxBurst), 32'd8);
        checkOutput("loss err_count_o", errCount, 32'd8);

        $display("[TB] overflow boundary");
        doClear();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("overflow at 64", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("overflow at 65", 32'(overflow), 32'd1);

        $display("[TB] push and pop at full");
        doClear();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("full push+pop overflow_o", 32'(overflow), 32'd0);
        checkOutput("full push+pop bit_count_o", bitCount, 32'd1);
        checkOutput("full push+pop err_count_o", errCount, 32'd0);

        $display("[TB] underflow boundary");
        doClear();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("underflow_o", 32'(underflow), 32'd1);
        checkOutput("underflow bit_count_o", bitCount, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("underflow push bit_count_o", bitCount, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("pop after underflow push", bitCount, 32'd1);
        checkOutput("pop after underflow err", errCount, 32'd0);

        $display("[TB] clear mid-run");
        doClear();
        runStream(20, 5, 6);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        doClear();
        runStream(40, 1000, 1000);
        checkOutput("post-clear bit_count_o", bitCount, 32'd40);
        checkOutput("post-clear err_count_o", errCount, 32'd0);
        checkOutput("post-clear max_burst_o", 32'(maxBurst), 32'd0);

        $display("[TB] async reset mid-run");
        runStream(20, 3, 3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async bit_count_o", bitCount, 32'd0);
        checkOutput("async err_count_o", errCount, 32'd0);
        checkOutput("async max_burst_o", 32'(maxBurst), 32'd0);
        checkOutput("async locked_o", 32'(locked), 32'd0);
        checkOutput("async flags", {30'd0, overflow, underflow}, 32'd0);
        modelReset();
        #1 rst = 1'b1;
        runStream(40, 1000, 1000);
        checkOutput("post-reset bit_count_o", bitCount, 32'd40);
        checkOutput("post-reset err_count_o", errCount, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] counter saturation");
        for (int c = 0; c < 22; c++) begin
            s4SrcValid = (c < 20);
            s4SrcBit   = (c % 3 == 0);
            s4DecValid = (c >= 2);
            s4DecBit   = (c >= 2) ? ((c - 2) % 3 != 0) : 1'b0;
            @(posedge clk);
            #1;
        end
        s4SrcValid = 1'b0;
        s4DecValid = 1'b0;
        checkOutput("sat err_count_o", 32'(s4Err), 32'd15);
        checkOutput("sat bit_count_o", 32'(s4Bit), 32'd15);
        checkOutput("sat max_burst_o", 32'(s4Max), 32'd20);
        checkOutput("sat locked_o", 32'(s4Locked), 32'd0);
        checkOutput("sat flags", {30'd0, s4Ovf, s4Udf}, 32'd0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
Downstream checker for the encoder/channel/decoder chain. It captures every source bit presented to the convolutional encoder and holds it in an alignment FIFO. Each decoded bit is compared against the oldest captured source bit. The block accumulates bit, error and burst statistics and runs a lock detector, so the bench reads pass/fail and BER directly instead of scraping display output.

Parameters:
DEPTH, 64, alignment FIFO depth in bits; power of 2, minimum 4; must exceed the worst-case decoder latency in bits.
LOCK_RUN, 32, consecutive matches needed to declare lock.
LOSS_RUN, 8, consecutive mismatches while locked that drop lock.
CNT_W, 32, width of the bit and error counters.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
clear_i  input  1  synchronous clear of statistics, FIFO and FSM
src_valid_i  input  1  source bit valid; same strobe as the encoder enable
src_bit_i  input  1  source bit; same bit as the encoder data input
dec_valid_i  input  1  decoded bit valid
dec_bit_i  input  1  decoded bit from the Viterbi decoder
err_pulse_o  output  1  one-cycle pulse, compared bit mismatched
bit_count_o  output  CNT_W  number of compared bits
err_count_o  output  CNT_W  number of mismatched bits
max_burst_o  output  16  longest run of consecutive mismatches
locked_o  output  1  lock FSM in LOCKED
overflow_o  output  1  sticky: push attempted while FIFO full
underflow_o  output  1  sticky: dec_valid_i while FIFO empty

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; FIFO empty; read and write pointers 0; current-run counter 0; FSM in HUNT.
- FIFO:
  - Push src_bit_i when src_valid_i=1.
  - Pop the head when dec_valid_i=1.
  - Full and empty flags are taken from the state at the start of the cycle.
  - Pointers are log2(DEPTH)+1 bits with natural wrap.
- Push while full and no pop in the same cycle: bit dropped, overflow_o set.
- Push and pop in the same cycle while full: both proceed; no overflow.
- Pop while empty: no compare, no counter change, underflow_o set.
  - A push in the same cycle is still accepted.
  - There is no bypass path.
- Compare: on a valid pop, mismatch = head XOR dec_bit_i. Results register one cycle after dec_valid_i:
  - err_pulse_o = mismatch.
  - bit_count_o increments by 1.
  - err_count_o increments by mismatch.
  - Both counters saturate at all-ones and never wrap.
- Burst tracking:
  - The current-run counter (16 bit, saturating) increments on a mismatch and clears to 0 on a match.
  - max_burst_o updates to the run value when the run exceeds it, in the same cycle as err_pulse_o.
- Lock FSM, states HUNT and LOCKED. It evaluates only on compared bits, using the updated run counters:
  - HUNT -> LOCKED when the consecutive-match count reaches LOCK_RUN. The match count is a separate saturating counter, cleared on mismatch.
  - LOCKED -> HUNT when the current mismatch run reaches LOSS_RUN; the match count clears at that point.
  - locked_o = (state==LOCKED), registered, and changes in the same cycle as the triggering err_pulse_o.
- clear_i:
  - Same effect as reset, but synchronous.
  - Overrides any push or pop in the same cycle.
  - Outputs read 0 the cycle after clear_i.
- Overflow and underflow flags are sticky until reset or clear_i.
- Statistics continue to accumulate in both FSM states.

Test Plan:
- Error-free loop: 200 random source bits, decoded stream equal to the source delayed 10 cycles -> bit_count_o=200, err_count_o=0, max_burst_o=0, locked_o rises on the 32nd compare, no sticky flags.
- Injected burst: after lock, invert 3 consecutive decoded bits -> err_count_o=3, max_burst_o=3, three err_pulse_o, locked_o stays 1.
- Loss of lock: after lock, invert 8 consecutive decoded bits -> locked_o drops on the 8th err_pulse_o; 32 clean bits later locked_o=1 again.
- Boundaries, each checked separately:
  - 64 pushes with no pop, then a 65th push -> overflow_o=1.
  - Simultaneous push and pop at full -> no overflow.
  - dec_valid_i with FIFO empty -> underflow_o=1, bit_count_o unchanged.
- Clear and reset mid-run: clear_i with 5 bits queued, then a stream aligned to bits pushed after the clear -> all counters restart from 0, no mismatches. Repeat with async rst pulsed between clock edges -> outputs 0 immediately.
- Saturation: with CNT_W=4, compare 20 all-mismatch bits -> err_count_o=15, bit_count_o=15.
